sar_ctrl: RTL
=============

Name: sar_ctrl

Overview:
- Synchronous successive-approximation controller for the SAR ADC example.
- Sequences the sampling switch, the comparator enable and the capacitive-DAC trial code.
- Resolves each bit from the comparator's NOR RS-latch outputs (q, qb); the latch idles at the forbidden/precharge state q=qb=1.
- Delivers an N-bit result with a done pulse, plus a sticky error flag for latch decisions that fail to resolve.

Parameters:
- N, 8: conversion resolution in bits, 2..16.
- SAMPLE_CYCLES, 2: cycles that sample is held high, at least 1.
- TIMEOUT, 4: maximum cycles to wait for a latch decision or latch precharge, at least 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- dec_q  input  1  latch q output; asynchronous, double-flopped inside the block before use.
- dec_qb  input  1  latch qb output; synchronised the same way as dec_q.
- sample  output  1  track/hold switch control; high means tracking.
- cmp_en  output  1  comparator enable; high means evaluate, low means precharge the latch to 11.
- dac_code  output  N  current trial code driven to the DAC.
- dout  output  N  last completed conversion result; holds until the next done.
- done  output  1  one-cycle pulse when dout updates.
- busy  output  1  high from start acceptance until the done cycle, inclusive.
- dec_err  output  1  sticky timeout flag; cleared only by rst or by a start that is accepted.

Behaviour:
- Reset values: state=IDLE, sample=0, cmp_en=0, dac_code=0, dout=0, done=0, busy=0, dec_err=0, bit index=N-1, internal result register=0, timer=0.
- Reset is asynchronous and may assert in any state.
- Reset mid-conversion aborts immediately: dout keeps 0 (its reset value) and no done pulse is produced.
- Decision encoding uses the synchronised pair {q,qb}:
  - 10: comparator output 1, meaning vin is at or above the DAC level; keep the trial bit.
  - 01: comparator output 0; clear the trial bit.
  - 11: precharged or undecided.
  - 00: illegal; treated as undecided.
- State IDLE: busy=0.
  - start=1 → SAMPLE.
  - On entry to SAMPLE: busy=1, dec_err cleared, result=0, index=N-1.
- State SAMPLE: sample=1 for exactly SAMPLE_CYCLES cycles, then → CMP.
  - On exit: sample=0, dac_code = result | (1<<index), timer=0.
- State CMP: cmp_en=1; timer increments each cycle.
  - Decision 10 or 01 → apply it to result[index], then → PRE.
  - Timer reaches TIMEOUT with no decision → bit is set to 1, dec_err=1, → PRE.
- State PRE: cmp_en=0; timer restarts.
  - Exits when {q,qb}=11 is seen, or when TIMEOUT expires (which also sets dec_err=1).
  - If index>0: index decrements, dac_code = updated result | (1<<(index-1)), → CMP.
  - If index==0: → DONE.
- State DONE, one cycle:
  - dout=result, dac_code=result, done=1, busy=1.
  - Then → IDLE; busy=0 on the next cycle.
- Latency with immediate decisions, counted from the edge that accepts start to the cycle with done=1: SAMPLE_CYCLES + 2N + 1 edges. This is 19 for the defaults.
- The synchroniser adds 2 cycles to decision and precharge detection. These count against the timer, so TIMEOUT must be at least 3 for a nominal latch. The defaults above assume ideal inputs; the bench compensates by presenting decisions already synchronised, or by adding 2 to every expected cycle count.
- start while busy is ignored and does not queue.
- start held high continuously yields back-to-back conversions, with one IDLE cycle between done and the next SAMPLE entry.
- Each bit is resolved MSB first. dac_code changes only on CMP entry and in DONE, and is stable throughout CMP.

Test Plan:
- Reset, then idle: all outputs 0 and the state stays IDLE for 10 cycles; asserting rst mid-CMP returns every output to 0 within the same cycle.
- N=8, input model vin code 0xA5 (a bench latch model returns 10 when dac_code ≤ 0xA5) → dac_code trials 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5, then dout=0xA5 with done for one cycle, latency per formula.
- Extreme codes: vin=0x00 gives dout=0x00 and vin=0xFF gives dout=0xFF; dec_err stays 0 in both.
- Latch stuck at 11 during bit 5 → after TIMEOUT cycles, bit 5 is forced to 1, dec_err=1 and stays 1 after done; the next accepted start clears it.
- start pulsed while busy → no effect on dac_code sequence or done count; start held high for 3 conversions → 3 done pulses separated by (latency+1) cycles.
- Latch returning 00 for 2 cycles and then 01 → treated as undecided, then the bit is cleared; no dec_err if resolved within TIMEOUT.

Source files
------------

// File: rtl/sar_ctrl.sv
// SAR ADC conversion sequencer: track/hold, comparator enable and binary-search trial code.
// Latch decisions pass through a two-flop synchroniser; every wait on the latch is bounded by TIMEOUT.
//
// state  | meaning
// IDLE   | waiting for start
// SAMPLE | tracking input, sample high for SAMPLE_CYCLES
// CMP    | comparator evaluating the current trial bit
// PRE    | latch precharging back to 11
// DONE   | one-cycle publish of the result
module sar_ctrl #(
  parameter int N             = 8,
  parameter int SAMPLE_CYCLES = 2,
  parameter int TIMEOUT       = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         dec_q,
  input  logic         dec_qb,
  output logic         sample,
  output logic         cmp_en,
  output logic [N-1:0] dac_code,
  output logic [N-1:0] dout,
  output logic         done,
  output logic         busy,
  output logic         dec_err
);

  localparam int TMAX = (SAMPLE_CYCLES > TIMEOUT) ? SAMPLE_CYCLES : TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = $clog2(N);

  typedef enum logic [2:0] {IDLE, SAMPLE, CMP, PRE, DONE} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  result_q, result_d;
  logic [N-1:0]  dac_q, dac_d;
  logic [N-1:0]  dout_q, dout_d;
  logic          err_q, err_d;
  logic [1:0]    sync1_q, sync2_q;
  logic [N-1:0]  bit_mask, next_mask;
  logic          decided, cmp_expired, pre_ready, pre_expired;

  // The synchroniser idles at the latch's precharge state so a fresh CMP never sees a stale decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= {dec_q, dec_qb};
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      idx_q    <= IW'(N - 1);
      result_q <= '0;
      dac_q    <= '0;
      dout_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      dac_q    <= dac_d;
      dout_q   <= dout_d;
      err_q    <= err_d;
    end
  end

  assign bit_mask    = N'(1) << idx_q;
  assign next_mask   = N'(1) << (idx_q - 1'b1);
  assign decided     = (sync2_q == 2'b10) || (sync2_q == 2'b01);
  assign cmp_expired = (timer_q == TW'(TIMEOUT - 1));
  assign pre_ready   = (sync2_q == 2'b11);
  assign pre_expired = (timer_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    result_d = result_q;
    dac_d    = dac_q;
    dout_d   = dout_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SAMPLE;
          timer_d  = '0;
          idx_d    = IW'(N - 1);
          result_d = '0;
          err_d    = 1'b0;
        end
      end
      SAMPLE: begin
        if (timer_q == TW'(SAMPLE_CYCLES - 1)) begin
          state_d = CMP;
          timer_d = '0;
          dac_d   = result_q | bit_mask;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      CMP: begin
        if (decided) begin
          if (sync2_q == 2'b10) result_d = result_q | bit_mask;
          state_d = PRE;
          timer_d = '0;
        end else if (cmp_expired) begin
          // An unresolved decision keeps the trial bit so the search still converges.
          result_d = result_q | bit_mask;
          err_d    = 1'b1;
          state_d  = PRE;
          timer_d  = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      PRE: begin
        if (pre_ready || pre_expired) begin
          if (!pre_ready) err_d = 1'b1;
          timer_d = '0;
          if (idx_q != '0) begin
            idx_d   = idx_q - 1'b1;
            dac_d   = result_q | next_mask;
            state_d = CMP;
          end else begin
            dout_d  = result_q;
            dac_d   = result_q;
            state_d = DONE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sample   = (state_q == SAMPLE);
  assign cmp_en   = (state_q == CMP);
  assign done     = (state_q == DONE);
  assign busy     = (state_q != IDLE);
  assign dac_code = dac_q;
  assign dout     = dout_q;
  assign dec_err  = err_q;

endmodule
